// File: rtl/vga_pkg.sv
// Shared VGA constants and sprite state encoding for the bouncing-ball design.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_TOTAL   = 525;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/bouncing_sprite_if.sv
// Raster strobes and control in, sprite position, hits and video out.
interface bouncing_sprite_if
    import vga_pkg::*;
#(
    parameter int XW = $clog2(VGA_H_VISIBLE),
    parameter int YW = $clog2(VGA_V_VISIBLE)
);
    logic          i_HBlank;
    logic          i_VBlank;
    logic          i_VReset;
    logic          i_Pause;
    logic          i_Serve;
    logic          o_Video;
    logic [XW-1:0] o_X;
    logic [YW-1:0] o_Y;
    logic          o_HitX;
    logic          o_HitY;
    logic [1:0]    o_State;

    modport master (
        output i_HBlank, i_VBlank, i_VReset, i_Pause, i_Serve,
        input  o_Video, o_X, o_Y, o_HitX, o_HitY, o_State
    );

    modport slave (
        input  i_HBlank, i_VBlank, i_VReset, i_Pause, i_Serve,
        output o_Video, o_X, o_Y, o_HitX, o_HitY, o_State
    );
endinterface

// File: rtl/bouncing_sprite_axis_bounce.sv
// One axis of sprite motion: position, direction and a one-cycle hit pulse on
// reaching either edge of the [0, LIMIT-SIZE] range.
module axis_bounce #(
    parameter int LIMIT     = 640,
    parameter int SIZE      = 10,
    parameter int SPEED     = 1,
    parameter int START     = 0,
    parameter int START_DIR = 1,
    parameter int W         = $clog2(LIMIT)
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         hit
);

    localparam logic [W:0]   MAX_POS   = (W+1)'(LIMIT - SIZE);
    localparam logic [W:0]   STEP_AMT  = (W+1)'(SPEED);
    localparam logic [W-1:0] START_POS = W'(START);
    localparam logic         START_D   = (START_DIR != 0);

    logic dir;

    // Returns {hit, dir, pos}; compares in W+1 bits so the far edge cannot wrap.
    function automatic logic [W+1:0] bounce(input logic [W:0] p, input logic d);
        logic [W:0] up;
        logic [W:0] dn;
        up = p + STEP_AMT;
        dn = p - STEP_AMT;
        if (d && (up >= MAX_POS))
            return {1'b1, 1'b0, MAX_POS[W-1:0]};
        else if (!d && (p <= STEP_AMT))
            return {1'b1, 1'b1, {W{1'b0}}};
        else if (d)
            return {1'b0, 1'b1, up[W-1:0]};
        else
            return {1'b0, 1'b0, dn[W-1:0]};
    endfunction

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || load) begin
            pos <= START_POS;
            dir <= START_D;
            hit <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (step)
                {hit, dir, pos} <= bounce({1'b0, pos}, dir);
        end
    end

endmodule

// File: rtl/bouncing_sprite.sv
// Bouncing ball generator: raster counters, registered sprite video and a
// serve/run/pause controller that advances the sprite once per frame strobe.
module bouncing_sprite
    import vga_pkg::*;
#(
    parameter int H_VISIBLE    = VGA_H_VISIBLE,
    parameter int V_VISIBLE    = VGA_V_VISIBLE,
    parameter int BALL_W       = 10,
    parameter int BALL_H       = 10,
    parameter int START_X      = 315,
    parameter int START_Y      = 99,
    parameter int START_DIR_X  = 1,
    parameter int START_DIR_Y  = 1,
    parameter int SPEED_X      = 1,
    parameter int SPEED_Y      = 1,
    parameter int SERVE_FRAMES = 60
) (
    input logic i_Clk,
    input logic i_Rst_n,
    bouncing_sprite_if.slave bus
);

    localparam int XW = $clog2(H_VISIBLE);
    localparam int YW = $clog2(V_VISIBLE);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          hb_p1;
    logic          video_p1;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hit_x;
    logic          hit_y;
    logic          move;
    logic          in_x;
    logic          in_y;
    state_t        state;
    logic [CW-1:0] serve_cnt;

    assign move = bus.i_VReset && !bus.i_Serve && (state == ST_RUN) && !bus.i_Pause;

    axis_bounce #(
        .LIMIT(H_VISIBLE), .SIZE(BALL_W), .SPEED(SPEED_X),
        .START(START_X), .START_DIR(START_DIR_X)
    ) u_axis_x (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .load(bus.i_Serve),
        .step(move), .pos(x), .hit(hit_x)
    );

    axis_bounce #(
        .LIMIT(V_VISIBLE), .SIZE(BALL_H), .SPEED(SPEED_Y),
        .START(START_Y), .START_DIR(START_DIR_Y)
    ) u_axis_y (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .load(bus.i_Serve),
        .step(move), .pos(y), .hit(hit_y)
    );

    assign in_x = ({1'b0, col} >= {1'b0, x}) &&
                  ({1'b0, col} <  ({1'b0, x} + (XW+1)'(BALL_W)));
    assign in_y = ({1'b0, row} >= {1'b0, y}) &&
                  ({1'b0, row} <  ({1'b0, y} + (YW+1)'(BALL_H)));

    // Stage p0 -> p1: counters describe the current pixel, video lands one cycle later.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            col      <= '0;
            row      <= '0;
            hb_p1    <= 1'b1;
            video_p1 <= 1'b0;
        end else begin
            col      <= bus.i_HBlank ? '0 : col + 1'b1;
            hb_p1    <= bus.i_HBlank;
            if (bus.i_VBlank)
                row <= '0;
            else if (bus.i_HBlank && !hb_p1)
                row <= row + 1'b1;
            video_p1 <= !bus.i_HBlank && !bus.i_VBlank && in_x && in_y;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n || bus.i_Serve) begin
            state     <= ST_SERVE;
            serve_cnt <= '0;
        end else if (bus.i_VReset) begin
            case (state)
                ST_SERVE: begin
                    if (serve_cnt == SERVE_LAST) begin
                        state     <= ST_RUN;
                        serve_cnt <= '0;
                    end else begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                ST_RUN:   if (bus.i_Pause) state <= ST_PAUSE;
                ST_PAUSE: if (!bus.i_Pause) state <= ST_RUN;
                default:  state <= ST_SERVE;
            endcase
        end
    end

    assign bus.o_Video = video_p1;
    assign bus.o_X     = x;
    assign bus.o_Y     = y;
    assign bus.o_HitX  = hit_x;
    assign bus.o_HitY  = hit_y;
    assign bus.o_State = state;

endmodule

// File: tb/tb_bouncing_sprite.sv
// Directed bench: default sprite, a right-edge sprite and a corner sprite share
// one raster stimulus; each result is compared against hand-derived values.
module tb_bouncing_sprite;

    localparam int LINE_PIX = 340;

    logic clk = 1'b0;
    logic rst_n, hb, vb, vr, pause, serve;
    logic hx_b, hx_c, hy_c;
    int   vectors = 0;
    int   errors  = 0;
    int   first, cnt;

    always #5 clk = ~clk;

    bouncing_sprite_if if_a ();
    bouncing_sprite_if if_b ();
    bouncing_sprite_if if_c ();

    assign if_a.i_HBlank = hb;  assign if_b.i_HBlank = hb;  assign if_c.i_HBlank = hb;
    assign if_a.i_VBlank = vb;  assign if_b.i_VBlank = vb;  assign if_c.i_VBlank = vb;
    assign if_a.i_VReset = vr;  assign if_b.i_VReset = vr;  assign if_c.i_VReset = vr;
    assign if_a.i_Pause  = pause; assign if_b.i_Pause = pause; assign if_c.i_Pause = pause;
    assign if_a.i_Serve  = serve; assign if_b.i_Serve = serve; assign if_c.i_Serve = serve;

    bouncing_sprite u_a (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_a));

    bouncing_sprite #(.START_X(628), .SERVE_FRAMES(1))
        u_b (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_b));

    bouncing_sprite #(.START_X(0), .START_Y(0), .START_DIR_X(0), .START_DIR_Y(0),
                      .SERVE_FRAMES(1))
        u_c (.i_Clk(clk), .i_Rst_n(rst_n), .bus(if_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe();
        @(negedge clk); vb = 1'b1; vr = 1'b1;
        @(negedge clk); vr = 1'b0;
        hx_b = if_b.o_HitX; hx_c = if_c.o_HitX; hy_c = if_c.o_HitY;
        @(negedge clk); vb = 1'b0;
        @(negedge clk);
    endtask

    task automatic sweep_line(output int f, output int n);
        f = -1; n = 0;
        for (int c = 0; c <= LINE_PIX + 2; c++) begin
            @(negedge clk);
            if (c > 0 && if_a.o_Video === 1'b1) begin
                if (f < 0) f = c - 1;
                n++;
            end
            hb = (c >= LINE_PIX);
        end
    endtask

    initial begin
        rst_n = 1'b0; hb = 1'b1; vb = 1'b1; vr = 1'b0; pause = 1'b0; serve = 1'b0;
        hx_b = 1'b0; hx_c = 1'b0; hy_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(if_a.o_State), 0);
        chk("rst_x",     32'(if_a.o_X), 315);
        chk("rst_y",     32'(if_a.o_Y), 99);
        chk("rst_video", 32'(if_a.o_Video), 0);
        chk("rst_hitx",  32'(if_a.o_HitX), 0);
        chk("rst_hity",  32'(if_a.o_HitY), 0);
        chk("rst_b_x",   32'(if_b.o_X), 628);
        rst_n = 1'b1;

        strobe();                                   // strobe 1: B and C enter RUN
        chk("b_run",   32'(if_b.o_State), 1);
        chk("b_x1",    32'(if_b.o_X), 628);
        chk("c_run",   32'(if_c.o_State), 1);
        strobe();                                   // strobe 2
        chk("b_x2",    32'(if_b.o_X), 629);
        chk("b_hit2",  32'(hx_b), 0);
        chk("c_hitx",  32'(hx_c), 1);
        chk("c_hity",  32'(hy_c), 1);
        chk("c_x0",    32'(if_c.o_X), 0);
        chk("c_y0",    32'(if_c.o_Y), 0);
        strobe();                                   // strobe 3
        chk("b_x3",    32'(if_b.o_X), 630);
        chk("b_hit3",  32'(hx_b), 1);
        chk("c_x1",    32'(if_c.o_X), 1);
        chk("c_y1",    32'(if_c.o_Y), 1);
        chk("c_nohit", 32'({hx_c, hy_c}), 0);
        strobe();                                   // strobe 4
        chk("b_x4",    32'(if_b.o_X), 629);
        chk("b_hit4",  32'(hx_b), 0);

        repeat (55) strobe();                       // total 59
        chk("a_serve59_state", 32'(if_a.o_State), 0);
        chk("a_serve59_x",     32'(if_a.o_X), 315);
        chk("a_serve59_y",     32'(if_a.o_Y), 99);
        strobe();                                   // 60th
        chk("a_run_state", 32'(if_a.o_State), 1);
        chk("a_run_x",     32'(if_a.o_X), 315);
        chk("a_run_y",     32'(if_a.o_Y), 99);

        repeat (10) strobe();
        chk("a_10f_x", 32'(if_a.o_X), 325);
        chk("a_10f_y", 32'(if_a.o_Y), 109);

        for (int ln = 0; ln <= 120; ln++) begin
            sweep_line(first, cnt);
            if (ln >= 109 && ln <= 118) begin
                chk($sformatf("video_first_l%0d", ln), 32'(first), 325);
                chk($sformatf("video_cnt_l%0d", ln),   32'(cnt), 10);
            end else begin
                chk($sformatf("video_first_l%0d", ln), 32'(first), 32'hFFFF_FFFF);
                chk($sformatf("video_cnt_l%0d", ln),   32'(cnt), 0);
            end
        end

        pause = 1'b1;
        strobe();
        chk("pause_state", 32'(if_a.o_State), 2);
        chk("pause_x",     32'(if_a.o_X), 325);
        repeat (5) strobe();
        chk("pause5_state", 32'(if_a.o_State), 2);
        chk("pause5_x",     32'(if_a.o_X), 325);
        chk("pause5_y",     32'(if_a.o_Y), 109);
        pause = 1'b0;
        strobe();
        chk("resume_state", 32'(if_a.o_State), 1);
        chk("resume_x",     32'(if_a.o_X), 325);
        strobe();
        chk("resume_move_x", 32'(if_a.o_X), 326);
        chk("resume_move_y", 32'(if_a.o_Y), 110);

        pause = 1'b1;
        strobe();
        chk("pause2_state", 32'(if_a.o_State), 2);
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
        chk("serve_state", 32'(if_a.o_State), 0);
        chk("serve_x",     32'(if_a.o_X), 315);
        chk("serve_y",     32'(if_a.o_Y), 99);
        pause = 1'b0;
        repeat (60) strobe();
        chk("reserve_state", 32'(if_a.o_State), 1);
        repeat (2) strobe();
        chk("reserve_x", 32'(if_a.o_X), 317);
        chk("reserve_y", 32'(if_a.o_Y), 101);

        for (int l = 0; l < 101; l++) begin
            @(negedge clk); hb = 1'b0;
            @(negedge clk); hb = 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < 322; c++) begin
            @(negedge clk); hb = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_video", 32'(if_a.o_Video), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_video", 32'(if_a.o_Video), 0);
        chk("mid_rst_state", 32'(if_a.o_State), 0);
        chk("mid_rst_x",     32'(if_a.o_X), 315);
        chk("mid_rst_y",     32'(if_a.o_Y), 99);
        chk("mid_rst_hits",  32'({if_a.o_HitX, if_a.o_HitY}), 0);
        rst_n = 1'b1; hb = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
